apb_requester: RTL and testbench

- Synthesizable, parametrised APB4 requester (bridge) that turns the bench-only stimulus into real RTL.
- Accepts single read/write commands on a valid/ready command port.
- Decodes the address to one of NUM_SLAVES completers and runs a full SETUP/ACCESS transfer with wait states.
- Returns read data and status on a valid/ready response port; sits between an upstream interconnect and the APB peripheral segment.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_addr_decode.sv | 34 +++
 rtl/apb_requester.sv | 218 +++++++++++++++++++++
 tb/tb_apb_requester.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester slice: FSM states, response status codes
// and the slave-index width helper.
package apb_pkg;

   localparam int PROT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_req_state_e;

   typedef enum logic [1:0] {
      RSP_OKAY,
      RSP_SLVERR,
      RSP_DECERR,
      RSP_TIMEOUT
   } apb_rsp_status_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a byte address to a completer index and
// one-hot select, flagging out-of-range, non-zero upper bits or misalignment.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_SLAVES    = 4,
   parameter int SLAVE_SEL_LSB = 12,
   localparam int SEL_W        = sel_width(NUM_SLAVES)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [SEL_W-1:0]      idx,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  dec_err
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int HI_LSB     = SLAVE_SEL_LSB + SEL_W;

   logic upper_err;
   logic range_err;
   logic align_err;

   always_comb begin
      idx       = addr[SLAVE_SEL_LSB +: SEL_W];
      upper_err = (addr >> HI_LSB) != '0;
      range_err = int'(idx) >= NUM_SLAVES;
      align_err = (addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
      dec_err   = upper_err || range_err || align_err;
      sel       = dec_err ? '0 : (NUM_SLAVES'(1) << idx);
   end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding command, decoded to a psel line, with status
// returned on a valid/ready response port. Define APB_REQ_TIMEOUT_EN for the ACCESS timeout.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SLAVE_SEL_LSB  = 12,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                             pclk,
   input  logic                             preset,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]            cmd_wdata,
   input  logic [STRB_WIDTH-1:0]            cmd_strb,
   input  logic [PROT_W-1:0]                cmd_prot,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [1:0]                       rsp_status,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   output logic [STRB_WIDTH-1:0]            pstrb,
   output logic [PROT_W-1:0]                pprot,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam int SEL_W = sel_width(NUM_SLAVES);

   if (!(DATA_WIDTH inside {8, 16, 32}) || NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("apb_requester: illegal parameter set");
   end

   apb_req_state_e          state_q,      state_d;
   logic                    cmd_ready_q,  cmd_ready_d;
   logic [NUM_SLAVES-1:0]   psel_q,       psel_d;
   logic                    penable_q,    penable_d;
   logic                    pwrite_q,     pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q,      paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q,     pwdata_d;
   logic [STRB_WIDTH-1:0]   pstrb_q,      pstrb_d;
   logic [PROT_W-1:0]       pprot_q,      pprot_d;
   logic [SEL_W-1:0]        idx_q,        idx_d;
   logic                    rsp_valid_q,  rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q,  rsp_rdata_d;
   apb_rsp_status_e         rsp_status_q, rsp_status_d;
`ifdef APB_REQ_TIMEOUT_EN
   localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOUT_W-1:0]       tout_q,       tout_d;
`endif

   logic [SEL_W-1:0]        dec_idx;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_err;
   logic                    pready_sel;
   logic                    pslverr_sel;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   apb_addr_decode #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_SLAVES   (NUM_SLAVES),
      .SLAVE_SEL_LSB(SLAVE_SEL_LSB)
   ) u_dec (
      .addr   (cmd_addr),
      .idx    (dec_idx),
      .sel    (dec_sel),
      .dec_err(dec_err)
   );

   // Masking with the registered select makes unselected completers invisible.
   always_comb begin
      pready_sel  = |(pready & psel_q);
      pslverr_sel = |(pslverr & psel_q);
      sel_rdata   = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d      = state_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      pprot_d      = pprot_q;
      idx_d        = idx_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_status_d = rsp_status_q;
`ifdef APB_REQ_TIMEOUT_EN
      tout_d       = tout_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pprot_d  = cmd_prot;
               pwdata_d = cmd_write ? cmd_wdata : '0;
               pstrb_d  = cmd_write ? cmd_strb : '0;
               idx_d    = dec_idx;
               if (dec_err) begin
                  state_d      = RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_rdata_d  = '0;
                  rsp_status_d = RSP_DECERR;
               end else begin
                  state_d = SETUP;
                  psel_d  = dec_sel;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
            tout_d    = '0;
`endif
         end
         ACCESS: begin
            if (pready_sel) begin
               state_d      = RESP;
               psel_d       = '0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_status_d = pslverr_sel ? RSP_SLVERR : RSP_OKAY;
               rsp_rdata_d  = (!pwrite_q && !pslverr_sel) ? sel_rdata : '0;
            end
`ifdef APB_REQ_TIMEOUT_EN
            else if (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d      = RESP;
               psel_d       = '0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
               rsp_rdata_d  = '0;
            end else begin
               tout_d = tout_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b0;
         psel_q       <= '0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         pprot_q      <= '0;
         idx_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= RSP_OKAY;
`ifdef APB_REQ_TIMEOUT_EN
         tout_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         pprot_q      <= pprot_d;
         idx_q        <= idx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_status_q <= rsp_status_d;
`ifdef APB_REQ_TIMEOUT_EN
         tout_q       <= tout_d;
`endif
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
   assign pprot      = pprot_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small four-completer APB memory model.
module tb_apb_requester;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_strb = '0;
   logic [2:0]  cmd_prot = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic [3:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [127:0] prdata;
   logic [3:0]  pready;
   logic [3:0]  pslverr;

   always #5 pclk = ~pclk;

   apb_requester #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4),
      .SLAVE_SEL_LSB(12), .TIMEOUT_CYCLES(16)
   ) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // Completer model: four words per completer, ready after ws ACCESS cycles.
   logic [31:0] mem [4][4];
   int          acc_cnt = 0;
   int          ws = 0;
   logic        stall = 1'b0;
   logic        err = 1'b0;
   logic [3:0]  stray = '0;

   function automatic logic [31:0] init_word(input int s, input int w);
      if (s == 1 && w == 1) return 32'hDEAD_BEEF;
      if (s == 2 && w == 2) return 32'h1234_5678;
      return 32'hA000_0000 | 32'(s << 8) | 32'(w);
   endfunction

   always @(posedge pclk) begin
      if (penable) acc_cnt <= acc_cnt + 1;
      else         acc_cnt <= 0;
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 4; w++) begin
            if (preset) mem[s][w] <= init_word(s, w);
         end
         if (!preset && psel[s] && penable && pready[s] && pwrite) begin
            for (int b = 0; b < 4; b++) begin
               if (pstrb[b]) mem[s][paddr[3:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      prdata = '0;
      for (int s = 0; s < 4; s++) prdata[s*32 +: 32] = mem[s][paddr[3:2]];
   end
   assign pready  = stray | (psel & {4{penable && !stall && (acc_cnt >= ws)}});
   assign pslverr = stray | (psel & {4{err}});

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int          r_lat, r_psel_cyc, r_acc;
   logic [3:0]  r_psel_or, r_pstrb;
   logic        r_stable;
   logic [31:0] r_rdata;
   logic [1:0]  r_status;
   logic        hold_ok;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = wdata; cmd_strb = strb; cmd_prot = 3'b010;
      tick();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
   endtask

   task automatic wait_rsp(input int budget);
      logic [31:0] a0, d0;
      logic [3:0]  s0;
      a0 = '0; d0 = '0; s0 = '0;
      r_lat = 1; r_psel_cyc = 0; r_acc = 0; r_psel_or = '0; r_pstrb = '0; r_stable = 1'b1;
      while (!rsp_valid && r_lat <= budget) begin
         if (|psel) begin
            if (r_psel_cyc == 0) begin
               a0 = paddr; d0 = pwdata; s0 = pstrb;
            end else if (paddr !== a0 || pwdata !== d0 || pstrb !== s0) begin
               r_stable = 1'b0;
            end
            r_psel_cyc++;
            r_psel_or = r_psel_or | psel;
            r_pstrb   = pstrb;
         end
         if (penable) r_acc++;
         tick();
         r_lat++;
      end
      if (!rsp_valid) check("rsp_wait_bound", rsp_valid, 1);
      r_rdata  = rsp_rdata;
      r_status = rsp_status;
   endtask

   task automatic take_rsp();
      check("resp_bus_idle", {psel, penable, cmd_ready}, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_dropped", rsp_valid, 0);
      check("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge pclk);
      #1;
      check("reset_outputs", {cmd_ready, rsp_valid, psel, penable, paddr, rsp_status}, 0);
      preset = 1'b0;
      tick();
      check("cmd_ready_after_reset", cmd_ready, 1);

      // zero-wait read from completer 1
      ws = 0;
      issue(1'b0, 32'h0000_1004, '0, '0);
      wait_rsp(20);
      check("rd1_latency", r_lat, 3);
      check("rd1_psel_cycles", r_psel_cyc, 2);
      check("rd1_psel", r_psel_or, 4'b0010);
      check("rd1_pstrb", r_pstrb, 0);
      check("rd1_rdata", r_rdata, 32'hDEAD_BEEF);
      check("rd1_status", r_status, 0);
      take_rsp();

      // byte write with three wait states, then read back
      ws = 3;
      issue(1'b1, 32'h0000_2008, 32'hFFFF_FFFF, 4'h1);
      wait_rsp(20);
      check("wr_latency", r_lat, 6);
      check("wr_psel_cycles", r_psel_cyc, 5);
      check("wr_stable", r_stable, 1);
      check("wr_pstrb", r_pstrb, 4'h1);
      check("wr_status", r_status, 0);
      check("wr_rdata", r_rdata, 0);
      take_rsp();
      ws = 0;
      issue(1'b0, 32'h0000_2008, '0, '0);
      wait_rsp(20);
      check("wr_readback", r_rdata, 32'h1234_56FF);
      check("wr_readback_status", r_status, 0);
      take_rsp();

      // decode errors: misaligned and beyond the select field
      issue(1'b0, 32'h0000_0003, '0, '0);
      wait_rsp(20);
      check("dec_unaligned_psel", r_psel_or, 0);
      check("dec_unaligned_latency", r_lat, 1);
      check("dec_unaligned_status", r_status, 2);
      check("dec_unaligned_rdata", r_rdata, 0);
      take_rsp();
      issue(1'b0, 32'h0000_5000, '0, '0);
      wait_rsp(20);
      check("dec_range_psel", r_psel_or, 0);
      check("dec_range_status", r_status, 2);
      check("dec_range_rdata", r_rdata, 0);
      take_rsp();

      // slave error on the second ACCESS cycle
      ws = 1; err = 1'b1;
      issue(1'b0, 32'h0000_0000, '0, '0);
      wait_rsp(20);
      check("slverr_psel_cycles", r_psel_cyc, 3);
      check("slverr_status", r_status, 1);
      check("slverr_rdata", r_rdata, 0);
      take_rsp();
      ws = 0; err = 1'b0;

      // stray ready/error from unselected completers must not end the transfer
      stall = 1'b1; stray = 4'b1101;
      issue(1'b0, 32'h0000_1008, '0, '0);
      repeat (4) tick();
      check("stray_still_access", {rsp_valid, psel, penable}, {1'b0, 4'b0010, 1'b1});
      stray = '0; stall = 1'b0;
      wait_rsp(20);
      check("stray_rdata", r_rdata, 32'hA000_0102);
      check("stray_status", r_status, 0);
      take_rsp();

      // never-ready completer
      stall = 1'b1;
      issue(1'b0, 32'h0000_1000, '0, '0);
`ifdef APB_REQ_TIMEOUT_EN
      wait_rsp(60);
      check("tmo_access_cycles", r_acc, 16);
      check("tmo_status", r_status, 3);
      check("tmo_rdata", r_rdata, 0);
      take_rsp();
      stall = 1'b0;
`else
      repeat (100) tick();
      check("no_tmo_still_access", {rsp_valid, psel, penable}, {1'b0, 4'b0010, 1'b1});
      stall = 1'b0;
      wait_rsp(20);
      check("no_tmo_rdata", r_rdata, 32'hA000_0100);
      check("no_tmo_status", r_status, 0);
      take_rsp();
`endif

      // reset asserted mid-ACCESS
      stall = 1'b1;
      issue(1'b0, 32'h0000_3000, '0, '0);
      tick();
      check("rst_in_access", {psel, penable}, {4'b1000, 1'b1});
      #3 preset = 1'b1;
      #1 check("rst_async_drop", {psel, penable, rsp_valid, cmd_ready}, 0);
      tick();
      preset = 1'b0; stall = 1'b0;
      tick();
      check("rst_recover", {cmd_ready, rsp_valid, psel}, {1'b1, 1'b0, 4'b0000});

      // response held under back-pressure
      issue(1'b0, 32'h0000_1004, '0, '0);
      wait_rsp(20);
      check("bp_rdata", r_rdata, 32'hDEAD_BEEF);
      hold_ok = 1'b1;
      repeat (5) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_status !== r_status ||
             cmd_ready !== 1'b0) hold_ok = 1'b0;
      end
      check("bp_hold_stable", hold_ok, 1);
      take_rsp();

      // rsp_ready high while idle does nothing
      rsp_ready = 1'b1;
      repeat (2) tick();
      check("idle_rsp_ready", {rsp_valid, cmd_ready, psel}, {1'b0, 1'b1, 4'b0000});
      rsp_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
